// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO pop handshake between a FIFO and its draining transmitter
interface fifo_uart_tx_if #(parameter int WL = 8);
  logic read_rq;
  logic empty;
  logic [WL-1:0] fifo_data;
  modport master (output read_rq, input empty, fifo_data);
  modport slave (input read_rq, output empty, fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO one word at a time and serialises each word as a UART frame
module fifo_uart_tx #(
  parameter int WL = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic n_rst,
  input logic enable,
  fifo_uart_tx_if.master fifo,
  output logic tx,
  output logic busy,
  output logic frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(WL + 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WL - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic ODD = PARITY_ODD != 0;
  localparam logic HAS_PAR = PARITY_EN != 0;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [BW-1:0] baud;
  logic [CW-1:0] cnt;
  logic [WL-1:0] shift;
  logic par;
  logic bit_end;
  logic start_ok;
  assign bit_end = baud == BAUD_LAST;
  assign start_ok = enable && !fifo.empty;
  // frame sequencer: pop, capture, then shift out start/data/parity/stop at the baud rate
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      baud <= '0;
      cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      fifo.read_rq <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == STOP && baud == BAUD_LAST - 1'b1 && cnt == STOP_LAST;
      fifo.read_rq <= 1'b0;
      baud <= (state inside {START, DATA, PARITY, STOP}) && !bit_end ? baud + 1'b1 : '0;
      case (state)
        IDLE: if (start_ok) begin
          state <= FETCH;
          fifo.read_rq <= 1'b1;
          busy <= 1'b1;
        end
        FETCH: state <= WAIT;
        WAIT: begin
          state <= START;
          shift <= fifo.fifo_data;
          par <= ^fifo.fifo_data ^ ODD;
          tx <= 1'b0;
          cnt <= '0;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx <= shift[0];
        end
        DATA: if (bit_end) begin
          if (cnt == DATA_LAST) begin
            state <= HAS_PAR ? PARITY : STOP;
            tx <= HAS_PAR ? par : 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            shift <= shift >> 1;
            tx <= shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (cnt == STOP_LAST) begin
            cnt <= '0;
            state <= start_ok ? FETCH : IDLE;
            fifo.read_rq <= start_ok;
            busy <= start_ok;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
